// File: rtl/dice_roller.sv
// Electronic dice: debounced pushbutton starts and stops a free-running odometer of die
// counters, and the value shown at release is held and driven to 7-segment displays.
module dice_roller #(
  parameter int unsigned FACES    = 6,
  parameter int unsigned DICE     = 2,
  parameter int unsigned DB_TICKS = 40000,
  parameter int unsigned DB_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  output logic [7*DICE-1:0]     segments,
  output logic [4*DICE-1:0]     values,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  button_out,
  output logic [15:0]           roll_count
);

  localparam int unsigned TickW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  typedef enum logic [1:0] {StIdle, StRoll, StShow} state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    case (v)
      4'd1:    seg_encode = 7'b1001111;
      4'd2:    seg_encode = 7'b0010010;
      4'd3:    seg_encode = 7'b0000110;
      4'd4:    seg_encode = 7'b1001100;
      4'd5:    seg_encode = 7'b0100100;
      4'd6:    seg_encode = 7'b0100000;
      4'd7:    seg_encode = 7'b0001111;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0000100;
      default: seg_encode = 7'b1111110;
    endcase
  endfunction

  logic                     sync1_q, sync2_q;
  logic [TickW-1:0]         tick_q, tick_d;
  logic [DB_DEPTH-1:0]      hist_q, hist_d;
  logic                     btn_q, btn_d, btn_prev_q;
  logic                     press_q, press_d, release_q, release_d;
  logic [DICE-1:0][3:0]     cnt_q, cnt_d, live, held_q, held_d;
  state_e                   state_q, state_d;
  logic                     busy_q, rv_q, rv_d;
  logic [15:0]              count_q, count_d;
  logic [7*DICE-1:0]        seg_q, seg_d;

  always_comb begin
    tick_d = tick_q;
    hist_d = hist_q;
    if (tick_q == TickW'(DB_TICKS - 1)) begin
      tick_d = '0;
      hist_d = (hist_q << 1) | DB_DEPTH'(sync2_q);
    end else begin
      tick_d = tick_q + TickW'(1);
    end
    btn_d = btn_q;
    if (&hist_q) btn_d = 1'b1;
    else if (~|hist_q) btn_d = 1'b0;
    press_d   = btn_prev_q & ~btn_q;
    release_d = ~btn_prev_q & btn_q;
  end

  // Odometer: a carry ripples to die k only when every lower die wraps this cycle.
  always_comb begin
    logic carry;
    carry = 1'b1;
    cnt_d = cnt_q;
    for (int k = 0; k < DICE; k++) begin
      live[k] = cnt_q[k] + 4'd1;
      if (carry) begin
        if (cnt_q[k] == 4'(FACES - 1)) begin
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    rv_d    = 1'b0;
    count_d = count_q;
    unique case (state_q)
      StIdle, StShow: if (press_q) state_d = StRoll;
      StRoll: begin
        if (release_q) begin
          state_d = StShow;
          held_d  = live;
          rv_d    = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    values = (state_q == StRoll) ? live : held_q;
    for (int k = 0; k < DICE; k++) seg_d[7*k +: 7] = seg_encode(values[4*k +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_q     <= '0;
      hist_q     <= '1;
      btn_q      <= 1'b1;
      btn_prev_q <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      cnt_q      <= '0;
      held_q     <= {DICE{4'(FACES)}};
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      count_q    <= '0;
      seg_q      <= {DICE{seg_encode(4'(FACES))}};
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      tick_q     <= tick_d;
      hist_q     <= hist_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_q;
      press_q    <= press_d;
      release_q  <= release_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      state_q    <= state_d;
      busy_q     <= (state_d == StRoll);
      rv_q       <= rv_d;
      count_q    <= count_d;
      seg_q      <= seg_d;
    end
  end

  assign segments     = seg_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign button_out   = btn_q;
  assign roll_count   = count_q;

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter FACES, default 6, faces per die, legal range 2..9.
REQ-002 SHALL have parameter DICE, default 2, number of dice, legal range 1..4.
REQ-003 SHALL have parameter DB_TICKS, default 40000, clk cycles between debounce samples.
REQ-004 SHALL have parameter DB_DEPTH, default 8, debounce history length in samples.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port button  input  1  raw asynchronous pushbutton, 0 = pressed.
REQ-008 SHALL have port segments  output  7*DICE  per-die 7-segment code, die k at [7k+6:7k], bit order {a,b,c,d,e,f,g}, active low.
REQ-009 SHALL have port values  output  4*DICE  per-die displayed value, die k at [4k+3:4k].
REQ-010 SHALL have port result_valid  output  1  one-cycle pulse when a new roll result is captured.
REQ-011 SHALL have port busy  output  1  high while in ROLL.
REQ-012 SHALL have port button_out  output  1  debounced button level.
REQ-013 SHALL have port roll_count  output  16  number of completed rolls, saturating.

Function
REQ-014 SHALL pass button through a 2-flop synchronizer before debounce; everything downstream uses the synchronized signal.
REQ-015 SHALL run a tick counter 0..DB_TICKS-1; on terminal count it wraps to 0 and shifts the synchronized button into a DB_DEPTH-bit history.
REQ-016 SHALL set button_out to 1 when the history is all ones, 0 when all zeros, else hold its value.
REQ-017 SHALL derive press as a one-cycle pulse on the button_out 1->0 transition and release on 0->1, both registered.
REQ-018 SHALL keep one counter per die, range 0..FACES-1: die 0 advances every cycle; die k>0 advances only in the cycle die k-1 wraps FACES-1->0 (odometer); all wrap to 0.
REQ-019 SHALL implement FSM states IDLE, ROLL, SHOW; reset state IDLE.
REQ-020 SHALL transition IDLE->ROLL and SHOW->ROLL on press; ROLL->SHOW on release; no other transitions.
REQ-021 SHALL, in ROLL, drive values[k] = counter[k]+1 live each cycle (animation); busy=1.
REQ-022 SHALL, on the ROLL->SHOW cycle, latch counter[k]+1 of that cycle into every held value, pulse result_valid for exactly that cycle, and increment roll_count unless it is 0xFFFF.
REQ-023 SHALL, in IDLE and SHOW, drive values from the held registers, constant until the next ROLL.
REQ-024 SHALL register segments from values: 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, any other=1111110 (dash); segments lag values by one cycle.
REQ-025 SHALL ignore press while already in ROLL and release while in IDLE/SHOW.

Reset
REQ-026 SHALL on rst: tick counter 0, history all ones, button_out 1, synchronizer flops 1, die counters 0, held values FACES, state IDLE, busy 0, result_valid 0, roll_count 0, segments = code for FACES, one cycle after rst deasserts.
REQ-027 SHALL on rst during ROLL abort with no result_valid pulse and no roll_count change.
REQ-028 SHALL, if button is held low across reset release, detect press only after DB_DEPTH full zero samples.

Verification (FACES=6, DICE=2, DB_TICKS=4, DB_DEPTH=4)
REQ-029 SHALL check reset: rst 1 cycle -> values=0x66, segments=14'b0100000_0100000, button_out=1, busy=0, roll_count=0.
REQ-030 SHALL check roll: button low 40 cycles then high 40 cycles -> busy rises, one result_valid pulse, latched values equal reference odometer+1 at release cycle, roll_count=1.
REQ-031 SHALL check bounce: button toggling every 3 cycles for 60 cycles from released -> button_out stays 1, no state change.
REQ-032 SHALL check odometer: die 1 advances only after die 0 reaches 5 and wraps; both wrap 5->0; values in ROLL always 1..6.
REQ-033 SHALL check reset mid-roll: rst asserted while busy=1 -> IDLE, values=0x66, no result_valid, roll_count unchanged.
REQ-034 SHALL check saturation: roll_count preset via 65536 rolls (or forced) -> stays 0xFFFF, result_valid still pulses.
